program_loader: RTL and testbench

Boot-time instruction-memory writer for the 24-bit ProtoCore ISA. Accepts a framed byte stream over a valid/ready interface and packs each group of three bytes into one 24-bit instruction word, opcode nibble first. Writes the words into instruction memory at consecutive addresses starting at 0. Holds the CPU in reset until a complete image has been written and validated.

---
 rtl/program_loader.sv | 148 ++++++++++++++
 tb/tb_program_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte stream to 24-bit instruction memory writer with CPU hold
module program_loader #(
    parameter int          ADDR_W = 8,
    parameter logic [7:0]  MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [23:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);
    localparam int CW = ADDR_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_B0, S_B1, S_B2, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] wc_q, wc_d;
    logic [23:0]   word_q, word_d;
    logic [7:0]    csum_q, csum_d;
    logic          halt_q, halt_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic [1:0]    code_q, code_d;
    logic          accept;

    // Ready depends on state only; WRITE is the single stall cycle
    assign rx_ready   = !rst && (state_q != S_WRITE);
    assign accept     = rx_valid && rx_ready;
    assign imem_we    = (state_q == S_WRITE);
    assign imem_addr  = imem_we ? wc_q[ADDR_W-1:0] : '0;
    assign imem_wdata = imem_we ? word_q : 24'd0;
    assign cpu_hold   = (state_q != S_DONE);
    assign load_done  = done_q;
    assign load_error = error_q;
    assign err_code   = code_q;
    assign word_count = wc_q;

    // Next-state logic: frame parsing, word assembly, checksum and halt tracking
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        wc_d    = wc_q;
        word_d  = word_q;
        csum_d  = csum_q;
        halt_d  = halt_q;
        done_d  = done_q;
        error_d = error_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept && rx_data == MAGIC) begin
                    state_d = S_LEN;
                    wc_d    = '0;
                    csum_d  = 8'd0;
                    halt_d  = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    code_d  = 2'b00;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0 || {24'd0, rx_data} > (32'd1 << ADDR_W)) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b01;
                    end else begin
                        n_d     = CW'(rx_data);
                        state_d = S_B0;
                    end
                end
            end
            S_B0, S_B1, S_B2: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    word_d = {word_q[15:0], rx_data};
                    if (state_q == S_B0) begin
                        if (rx_data[7:4] == 4'hF) begin
                            halt_d = 1'b1;
                        end
                        state_d = S_B1;
                    end else if (state_q == S_B1) begin
                        state_d = S_B2;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wc_d    = wc_q + CW'(1);
                state_d = (wc_d == n_q) ? S_CSUM : S_B0;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data != csum_q) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b10;
                    end else if (!halt_q) begin
                        state_d = S_ERROR;
                        error_d = 1'b1;
                        code_d  = 2'b11;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            wc_q    <= '0;
            word_q  <= 24'd0;
            csum_q  <= 8'd0;
            halt_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            wc_q    <= wc_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            halt_q  <= halt_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [23:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [1:0]  err_code;
    logic [8:0]  word_count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic        prev_we = 1'b0;

    program_loader #(.ADDR_W(8), .MAGIC(8'hA5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_done(load_done),
        .load_error(load_error), .err_code(err_code), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes whenever the DUT strobes imem_we
    always @(negedge clk) begin
        if (!rst) begin
            chk("rx_ready_vs_write", int'(rx_ready), int'(!imem_we));
            if (imem_we) begin
                chk("we_single_cycle", int'(prev_we), 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=none", imem_addr, imem_wdata);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("write_addr", int'(imem_addr), int'(e[31:24]));
                    chk("write_data", int'(imem_wdata), int'(e[23:0]));
                end
            end
            prev_we = imem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout byte=%0h rx_ready=0 required=1", b);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_valid();
        exp_q.push_back({8'h00, 24'h812305});
        exp_q.push_back({8'h01, 24'hF00000});
        send(8'hA5, 0); send(8'h02, 0);
        send(8'h81, 0); send(8'h23, 0); send(8'h05, 0);
        send(8'hF0, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h57, 0);
    endtask

    task automatic chk_status(input string tag, input int done, input int err,
                              input int code, input int hold, input int wc);
        chk({tag, "_done"}, int'(load_done), done);
        chk({tag, "_error"}, int'(load_error), err);
        chk({tag, "_code"}, int'(err_code), code);
        chk({tag, "_hold"}, int'(cpu_hold), hold);
        chk({tag, "_wc"}, int'(word_count), wc);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rx_ready"}, int'(rx_ready), 0);
        chk({tag, "_we"}, int'(imem_we), 0);
        chk({tag, "_addr"}, int'(imem_addr), 0);
        chk({tag, "_wdata"}, int'(imem_wdata), 0);
        chk({tag, "_hold"}, int'(cpu_hold), 1);
        chk({tag, "_done"}, int'(load_done), 0);
        chk({tag, "_error"}, int'(load_error), 0);
        chk({tag, "_code"}, int'(err_code), 0);
        chk({tag, "_wc"}, int'(word_count), 0);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Valid load
        send_valid();
        chk_status("valid", 1, 0, 0, 0, 2);

        // Bad checksum, both words still written
        exp_q.push_back({8'h00, 24'h812305});
        exp_q.push_back({8'h01, 24'hF00000});
        send(8'hA5, 0); send(8'h02, 0);
        send(8'h81, 0); send(8'h23, 0); send(8'h05, 0);
        send(8'hF0, 0); send(8'h00, 0); send(8'h00, 0);
        send(8'h58, 0);
        chk_status("badcsum", 0, 1, 2, 1, 2);

        // Missing HALT
        exp_q.push_back({8'h00, 24'h012300});
        send(8'hA5, 0); send(8'h01, 0);
        send(8'h01, 0); send(8'h23, 0); send(8'h00, 0);
        send(8'h22, 0);
        chk_status("nohalt", 0, 1, 3, 1, 1);

        // Zero length, then restart from ERROR
        send(8'hA5, 0); send(8'h00, 0);
        chk_status("zerolen", 0, 1, 1, 1, 0);
        send_valid();
        chk_status("restart", 1, 0, 0, 0, 2);

        // Framing and back-pressure: leading junk, gaps, bytes held through WRITE
        exp_q.push_back({8'h00, 24'h812305});
        exp_q.push_back({8'h01, 24'hF00000});
        send(8'h00, 1); send(8'hFF, 1);
        chk("junk_keeps_done", int'(load_done), 1);
        send(8'hA5, 1);
        chk("magic_hold", int'(cpu_hold), 1);
        chk("magic_clears_done", int'(load_done), 0);
        send(8'h02, 1);
        send(8'h81, 1); send(8'h23, 1); send(8'h05, 0);
        send(8'hF0, 1); send(8'h00, 1); send(8'h00, 0);
        send(8'h57, 1);
        chk_status("bp", 1, 0, 0, 0, 2);

        // Reset mid-load after 4 payload bytes
        exp_q.push_back({8'h00, 24'h812305});
        send(8'hA5, 0); send(8'h02, 0);
        send(8'h81, 0); send(8'h23, 0); send(8'h05, 0);
        send(8'hF0, 0);
        chk("midload_wc", int'(word_count), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        send_valid();
        chk_status("after_rst", 1, 0, 0, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
